// File: rtl/matmul_sequencer.sv
// Sequences one 4x4 multiply: operand fetch into the datapath, latency wait, result drain to memory.
// Optional watchdog abort on stalled handshakes when MATMUL_SEQ_TIMEOUT_EN is defined.
module matmul_sequencer #(
    parameter int WIDTH        = 8,
    parameter int NUM_ELEMENTS = 4,
    parameter int MATRIX_WIDTH = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int MULT_LATENCY = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         src_addr,
    input  logic [ADDR_WIDTH-1:0]         dst_addr,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          mem_rd_req,
    output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
    input  logic                          mem_rd_valid,
    input  logic [NUM_ELEMENTS*WIDTH-1:0] mem_rdata,
    output logic [NUM_ELEMENTS*WIDTH-1:0] mm_rdata,
    output logic                          mm_read_en,
    output logic                          mm_write_en,
    input  logic                          mm_write_ready,
    input  logic [NUM_ELEMENTS*WIDTH-1:0] mm_res,
    output logic                          mem_wr_req,
    output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
    output logic [NUM_ELEMENTS*WIDTH-1:0] mem_wdata,
    input  logic                          mem_wr_ack
);
    localparam int DW          = NUM_ELEMENTS * WIDTH;
    localparam int LOAD_BEATS  = MATRIX_WIDTH * MATRIX_WIDTH / 2;
    localparam int STORE_BEATS = MATRIX_WIDTH;
    localparam int CNT_W       = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_STORE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, wr_addr_q, wr_addr_d;
    logic [DW-1:0]         rdata_q, rdata_d, wdata_q, wdata_d;
    logic                  rd_req_q, rd_req_d, read_en_q, read_en_d;
    logic                  write_en_q, write_en_d, wr_req_q, wr_req_d, done_q, done_d;

`ifdef MATMUL_SEQ_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;
    logic       err_q, err_d;
    logic       waiting;

    assign waiting = (rd_req_q && !mem_rd_valid) || (write_en_q && !mm_write_ready)
                   || (wr_req_q && !mem_wr_ack);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rd_req_d   = rd_req_q;
        rdata_d    = rdata_q;
        read_en_d  = 1'b0;
        write_en_d = write_en_q;
        wr_req_d   = wr_req_q;
        wr_addr_d  = wr_addr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d    = src_addr;
                    dst_d    = dst_addr;
                    cnt_d    = '0;
                    rd_req_d = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (rd_req_q && mem_rd_valid) begin
                    rdata_d   = mem_rdata;
                    read_en_d = 1'b1;
                    if (cnt_q == CNT_W'(LOAD_BEATS - 1)) begin
                        cnt_d    = '0;
                        rd_req_d = 1'b0;
                        state_d  = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (cnt_q == CNT_W'(MULT_LATENCY - 1)) begin
                    cnt_d      = '0;
                    write_en_d = 1'b1;
                    state_d    = S_STORE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STORE: begin
                // Result read and memory write alternate; only one of them is ever in flight.
                if (write_en_q && mm_write_ready) begin
                    wdata_d    = mm_res;
                    wr_req_d   = 1'b1;
                    wr_addr_d  = dst_q + ADDR_WIDTH'(cnt_q);
                    write_en_d = 1'b0;
                end else if (wr_req_q && mem_wr_ack) begin
                    wr_req_d = 1'b0;
                    if (cnt_q == CNT_W'(STORE_BEATS - 1)) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d      = cnt_q + CNT_W'(1);
                        write_en_d = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef MATMUL_SEQ_TIMEOUT_EN
        err_d = 1'b0;
        wd_d  = '0;
        if (waiting) begin
            if (wd_q == 8'd254) begin
                state_d    = S_IDLE;
                cnt_d      = '0;
                rd_req_d   = 1'b0;
                read_en_d  = 1'b0;
                write_en_d = 1'b0;
                wr_req_d   = 1'b0;
                done_d     = 1'b0;
                err_d      = 1'b1;
            end else begin
                wd_d = wd_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            rd_req_q   <= 1'b0;
            rdata_q    <= '0;
            read_en_q  <= 1'b0;
            write_en_q <= 1'b0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rd_req_q   <= rd_req_d;
            rdata_q    <= rdata_d;
            read_en_q  <= read_en_d;
            write_en_q <= write_en_d;
            wr_req_q   <= wr_req_d;
            wr_addr_q  <= wr_addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
        end
    end

`ifdef MATMUL_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign mem_rd_req  = rd_req_q;
    assign mem_rd_addr = rd_req_q ? src_q + ADDR_WIDTH'(cnt_q) : '0;
    assign mm_rdata    = rdata_q;
    assign mm_read_en  = read_en_q;
    assign mm_write_en = write_en_q;
    assign mem_wr_req  = wr_req_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wdata   = wdata_q;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: negedge memory/datapath responders, logged traffic checked against hand-derived addresses and data.
module tb_matmul_sequencer;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] src_addr, dst_addr, mem_rd_addr, mem_wr_addr;
    logic        busy, done, err, mem_rd_req, mm_read_en, mm_write_en, mem_wr_req;
    logic        mem_rd_valid = 1'b0, mm_write_ready = 1'b0, mem_wr_ack = 1'b0;
    logic [31:0] mem_rdata = '0, mm_res = '0, mm_rdata, mem_wdata;

    matmul_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .busy(busy), .done(done), .err(err), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata), .mm_rdata(mm_rdata),
        .mm_read_en(mm_read_en), .mm_write_en(mm_write_en), .mm_write_ready(mm_write_ready),
        .mm_res(mm_res), .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
        .mem_wdata(mem_wdata), .mem_wr_ack(mem_wr_ack)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction
    // Identity A times B=1..16 (row-major): column c of the product is B's column c.
    function automatic logic [31:0] res_word(input int c);
        return {8'(c + 13), 8'(c + 9), 8'(c + 5), 8'(c + 1)};
    endfunction

    bit          rd_on = 1'b1;
    int          rd_delay = 0, wr_delay = 0;
    int          rd_wait = 0, wr_wait = 0, col_tb = 0, stab_err = 0;
    logic [15:0] rd_first, wr_first_a;
    logic [31:0] wr_first_d;
    logic [15:0] rd_log[$], wr_alog[$];
    logic [31:0] rden_log[$], wr_dlog[$];
    int          done_cnt = 0, err_cnt = 0, viol = 0, done_cyc = 0;
    int          last_rden_cyc = 0, first_wren_cyc = 0;
    bit          wren_seen = 1'b0;

    always @(negedge clk) begin : mem_rd_model
        if (reset) begin
            mem_rd_valid = 1'b0;
            rd_wait      = 0;
        end else if (mem_rd_valid) begin
            mem_rd_valid = 1'b0;
        end else if (mem_rd_req && rd_on) begin
            if (rd_wait == 0) rd_first = mem_rd_addr;
            else if (mem_rd_addr !== rd_first) stab_err++;
            if (rd_wait < rd_delay) rd_wait++;
            else begin
                mem_rdata    = rd_word(mem_rd_addr);
                mem_rd_valid = 1'b1;
                rd_log.push_back(mem_rd_addr);
                rd_wait      = 0;
            end
        end else if (rd_wait != 0) begin
            stab_err++;
            rd_wait = 0;
        end
    end

    always @(negedge clk) begin : mem_wr_model
        if (reset) begin
            mem_wr_ack = 1'b0;
            wr_wait    = 0;
        end else if (mem_wr_ack) begin
            mem_wr_ack = 1'b0;
        end else if (mem_wr_req) begin
            if (wr_wait == 0) begin
                wr_first_a = mem_wr_addr;
                wr_first_d = mem_wdata;
            end else if (mem_wr_addr !== wr_first_a || mem_wdata !== wr_first_d) stab_err++;
            if (wr_wait < wr_delay) wr_wait++;
            else begin
                mem_wr_ack = 1'b1;
                wr_alog.push_back(mem_wr_addr);
                wr_dlog.push_back(mem_wdata);
                wr_wait    = 0;
            end
        end
    end

    always @(negedge clk) begin : datapath_model
        if (reset || !busy) begin
            mm_write_ready = 1'b0;
            col_tb         = 0;
        end else if (mm_write_ready) begin
            mm_write_ready = 1'b0;
        end else if (mm_write_en) begin
            mm_res         = res_word(col_tb);
            mm_write_ready = 1'b1;
            col_tb++;
        end
    end

    always @(negedge clk) begin : monitor
        if (mm_read_en) begin
            rden_log.push_back(mm_rdata);
            last_rden_cyc = cyc;
        end
        if (!busy) wren_seen = 1'b0;
        else if (mm_write_en && !wren_seen) begin
            wren_seen      = 1'b1;
            first_wren_cyc = cyc;
        end
        if (mm_write_en && mem_wr_req) viol++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
    end

    int b_rd, b_en, b_wr, b_done, b_err, b_viol, b_stab;
    task automatic snap();
        b_rd = rd_log.size(); b_en = rden_log.size(); b_wr = wr_alog.size();
        b_done = done_cnt; b_err = err_cnt; b_viol = viol; b_stab = stab_err;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic kick(input logic [15:0] s, input logic [15:0] d, output int c0);
        snap();
        start = 1'b1; src_addr = s; dst_addr = d;
        step();
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == b_done && k < budget) begin
            step();
            k++;
        end
        chk({tag, " done_seen"}, 64'(done_cnt != b_done), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ctl"}, {busy, done, err, mem_rd_req, mm_read_en, mm_write_en, mem_wr_req}, '0);
        chk({tag, " buses"}, {mem_rd_addr, mem_wr_addr, mem_wdata}, '0);
        chk({tag, " mm_rdata"}, mm_rdata, '0);
    endtask

    task automatic chk_job(input string tag, input logic [15:0] s, input logic [15:0] d);
        chk({tag, " rd_count"}, rd_log.size() - b_rd, 8);
        chk({tag, " rden_count"}, rden_log.size() - b_en, 8);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ea;
            ea = s + 16'(i);
            if (b_rd + i < rd_log.size()) chk({tag, " rd_addr"}, rd_log[b_rd + i], ea);
            if (b_en + i < rden_log.size()) chk({tag, " mm_rdata"}, rden_log[b_en + i], rd_word(ea));
        end
        chk({tag, " wr_count"}, wr_alog.size() - b_wr, 4);
        for (int c = 0; c < 4; c++) begin
            if (b_wr + c < wr_alog.size()) begin
                chk({tag, " wr_addr"}, wr_alog[b_wr + c], d + 16'(c));
                chk({tag, " wr_data"}, wr_dlog[b_wr + c], res_word(c));
            end
        end
        chk({tag, " done_pulses"}, done_cnt - b_done, 1);
        chk({tag, " wren_during_wr"}, viol - b_viol, 0);
        chk({tag, " hold_stable"}, stab_err - b_stab, 0);
        chk({tag, " err_pulses"}, err_cnt - b_err, 0);
    endtask

    initial begin
        int c0;
        int k;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0;
        repeat (3) step();
        chk_zero("reset_held");
        reset = 1'b0;
        step();
        chk_zero("after_reset");

        // Nominal zero-wait job
        kick(16'h0100, 16'h0200, c0);
        chk("nom first_req", {busy, mem_rd_req, mem_rd_addr}, {2'b11, 16'h0100});
        wait_done("nom", 200);
        chk("nom done_latency", done_cyc - c0, 26);
        chk("nom compute_gap", first_wren_cyc - last_rden_cyc, 3);
        step();
        chk("nom after_done", {busy, done}, 2'b00);
        chk_job("nom", 16'h0100, 16'h0200);

        // Backpressure on both memory ports
        rd_delay = 5; wr_delay = 3;
        kick(16'h1000, 16'h2000, c0);
        wait_done("bp", 400);
        step();
        chk_job("bp", 16'h1000, 16'h2000);
        rd_delay = 0; wr_delay = 0;

        // Source address wrap
        kick(16'hFFFC, 16'h0010, c0);
        wait_done("wrap", 200);
        step();
        chk_job("wrap", 16'hFFFC, 16'h0010);

        // start while busy must be ignored
        kick(16'h0300, 16'h0400, c0);
        k = 0;
        while (rden_log.size() - b_en < 8 && k < 100) begin step(); k++; end
        chk("busy_start reached_compute", 64'(rden_log.size() - b_en), 64'd8);
        start = 1'b1; src_addr = 16'h0500; dst_addr = 16'h0600;
        step();
        start = 1'b0;
        chk("busy_start still_busy", busy, 1'b1);
        wait_done("busy_start", 200);
        step();
        chk_job("busy_start", 16'h0300, 16'h0400);

        // Reset in the middle of LOAD
        kick(16'h0700, 16'h0800, c0);
        k = 0;
        while (rden_log.size() - b_en < 4 && k < 100) begin step(); k++; end
        reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        step(); step();
        reset = 1'b0;
        repeat (20) step();
        chk("mid_reset no_done", done_cnt - b_done, 0);
        kick(16'h0700, 16'h0800, c0);
        chk("restart first_addr", mem_rd_addr, 16'h0700);
        wait_done("restart", 200);
        step();
        chk_job("restart", 16'h0700, 16'h0800);

        // Read data never arrives: without the watchdog the wait is unbounded
        rd_on = 1'b0;
        kick(16'h0900, 16'h0A00, c0);
        repeat (300) step();
        chk("stall err_pulses", err_cnt - b_err, 0);
        chk("stall still_waiting", {busy, mem_rd_req, mem_rd_addr}, {2'b11, 16'h0900});
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd_on = 1'b1;
        step();
        chk("stall recovered", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
